// File: rtl/serv_seq.sv
// serv_seq: W-bit-per-cycle sequencer for the bit-serial core.
// It owns instruction fetch, register-file read requests and the bit-position
// counter. It also runs the init/final two-pass sequencing, the data-bus and
// shift waits, and trap entry (misalignment or timer interrupt).
// Optional build macro: SERV_SEQ_MDU_EN adds an MDU handshake
// (i_mdu_op / o_mdu_valid / i_mdu_ready) and an MDU wait state.
module serv_seq #(
   parameter int W = 1
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_ibus_ack,
   output logic       o_ibus_cyc,
   input  logic       i_two_stage,
   input  logic       i_mem_op,
   input  logic       i_shift_op,
   input  logic       i_sh_done,
   input  logic       i_misalign,
   input  logic       i_timer_irq,
   input  logic       i_timer_irq_en,
   output logic       o_rf_rreq,
   input  logic       i_rf_ready,
   output logic       o_dbus_cyc,
   input  logic       i_dbus_ack,
   output logic [4:0] o_cnt,
   output logic       o_cnt_en,
   output logic       o_init,
   output logic       o_cnt_done,
   output logic       o_ctrl_pc_en,
`ifdef SERV_SEQ_MDU_EN
   input  logic       i_mdu_op,
   output logic       o_mdu_valid,
   input  logic       i_mdu_ready,
`endif
   output logic       o_trap
);

   generate
      if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16)) begin : g_bad_w
         $error("serv_seq: W must be one of 1, 2, 4, 8, 16");
      end
   endgenerate

   localparam logic [4:0] LP_STEP = 5'(W);
   localparam logic [4:0] LP_LAST = 5'(32 - W);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_RFWAIT = 3'd1,
      ST_RUN    = 3'd2,
      ST_MEM    = 3'd3,
      ST_SHIFT  = 3'd4
`ifdef SERV_SEQ_MDU_EN
      ,
      ST_MDU    = 3'd5
`endif
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [4:0] r_cnt;
   logic [4:0] w_cnt_nxt;
   logic       r_trap;
   logic       w_trap_nxt;
   logic       r_final;      // init pass of this instruction already done
   logic       w_final_nxt;
   logic       r_init;
   logic       w_init_nxt;
   logic       w_rreq_nxt;

   logic       r_ibus_cyc;
   logic       r_dbus_cyc;
   logic       r_rreq;
   logic       r_cnt_en;
   logic       r_cnt_done;
   logic       r_pc_arm;     // last cycle of a final pass
`ifdef SERV_SEQ_MDU_EN
   logic       r_mdu_valid;
`endif

   // State register of the sequencing FSM.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus the counter, trap, pass and read-request updates.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_trap_nxt  = r_trap;
      w_final_nxt = r_final;
      w_init_nxt  = r_init;
      w_rreq_nxt  = 1'b0;
      case (r_state)
         ST_FETCH: begin
            // An ack is only meaningful while the fetch request is on the bus.
            if (i_ibus_ack && r_ibus_cyc) begin
               w_trap_nxt  = i_timer_irq & i_timer_irq_en;
               w_final_nxt = 1'b0;
               w_rreq_nxt  = 1'b1;
               w_state_nxt = ST_RFWAIT;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_RFWAIT: begin
            if (i_rf_ready) begin
               w_cnt_nxt   = 5'd0;
               w_init_nxt  = i_two_stage & ~r_trap & ~r_final;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_RFWAIT;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = r_cnt + LP_STEP;
            if (r_cnt_done) begin
               if (r_init) begin
                  w_final_nxt = 1'b1;
                  if (i_misalign) begin
                     w_trap_nxt  = 1'b1;
                     w_rreq_nxt  = 1'b1;
                     w_state_nxt = ST_RFWAIT;
`ifdef SERV_SEQ_MDU_EN
                  end else if (i_mdu_op) begin
                     w_state_nxt = ST_MDU;
`endif
                  end else if (i_mem_op) begin
                     w_state_nxt = ST_MEM;
                  end else if (i_shift_op) begin
                     w_state_nxt = ST_SHIFT;
                  end else begin
                     w_rreq_nxt  = 1'b1;
                     w_state_nxt = ST_RFWAIT;
                  end
               end else if (i_misalign && !r_trap) begin
                  // Bad jump/branch target: rerun as a trap-entry pass.
                  w_trap_nxt  = 1'b1;
                  w_rreq_nxt  = 1'b1;
                  w_state_nxt = ST_RFWAIT;
               end else begin
                  w_trap_nxt  = 1'b0;
                  w_init_nxt  = 1'b0;
                  w_state_nxt = ST_FETCH;
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_MEM: begin
            if (i_dbus_ack && r_dbus_cyc) begin
               w_rreq_nxt  = 1'b1;
               w_state_nxt = ST_RFWAIT;
            end else begin
               w_state_nxt = ST_MEM;
            end
         end
         ST_SHIFT: begin
            if (i_sh_done) begin
               w_rreq_nxt  = 1'b1;
               w_state_nxt = ST_RFWAIT;
            end else begin
               w_state_nxt = ST_SHIFT;
            end
         end
`ifdef SERV_SEQ_MDU_EN
         ST_MDU: begin
            if (i_mdu_ready) begin
               w_rreq_nxt  = 1'b1;
               w_state_nxt = ST_RFWAIT;
            end else begin
               w_state_nxt = ST_MDU;
            end
         end
`endif
         default: begin
            // Unreachable encoding: recover by refetching from a clean state.
            w_cnt_nxt   = 5'd0;
            w_trap_nxt  = 1'b0;
            w_final_nxt = 1'b0;
            w_init_nxt  = 1'b0;
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   // Bit counter, trap flag and pass-tracking registers.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= 5'd0;
         r_trap  <= 1'b0;
         r_final <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_trap  <= w_trap_nxt;
         r_final <= w_final_nxt;
         r_init  <= w_init_nxt;
      end
   end

   // Registered handshake and datapath-control outputs, decoded from the next state.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ibus_cyc  <= 1'b0;
         r_dbus_cyc  <= 1'b0;
         r_rreq      <= 1'b0;
         r_cnt_en    <= 1'b0;
         r_cnt_done  <= 1'b0;
         r_pc_arm    <= 1'b0;
`ifdef SERV_SEQ_MDU_EN
         r_mdu_valid <= 1'b0;
`endif
      end else begin
         r_ibus_cyc  <= (w_state_nxt == ST_FETCH);
         r_dbus_cyc  <= (w_state_nxt == ST_MEM);
         r_rreq      <= w_rreq_nxt;
         r_cnt_en    <= (w_state_nxt == ST_RUN);
         r_cnt_done  <= (w_state_nxt == ST_RUN) && (w_cnt_nxt == LP_LAST);
         r_pc_arm    <= (w_state_nxt == ST_RUN) && (w_cnt_nxt == LP_LAST) && !w_init_nxt;
`ifdef SERV_SEQ_MDU_EN
         r_mdu_valid <= (w_state_nxt == ST_MDU);
`endif
      end
   end

   assign o_ibus_cyc = r_ibus_cyc;
   assign o_dbus_cyc = r_dbus_cyc;
   assign o_rf_rreq  = r_rreq;
   assign o_cnt      = r_cnt;
   assign o_cnt_en   = r_cnt_en;
   assign o_init     = r_init;
   assign o_cnt_done = r_cnt_done;
   assign o_trap     = r_trap;
   // i_misalign only becomes valid in the cnt_done cycle itself, so the PC
   // write of a non-trap pass with a bad target must be vetoed combinationally.
   assign o_ctrl_pc_en = r_pc_arm & ~(i_misalign & ~r_trap);
`ifdef SERV_SEQ_MDU_EN
   assign o_mdu_valid = r_mdu_valid;
`endif

endmodule
